// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The master drives operands and result acceptance; the slave is the adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Nibble-serial wide adder: one 4-bit carry-select adder reused for WIDTH/4 cycles,
// with the carry chained through a register between nibbles.

// 4-bit carry-select adder: low pair ripples, high pair precomputed for both carries.
module carry_select (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       carry,
    output logic [3:0] s,
    output logic       cout
);
    logic [2:0] w_lo;
    logic [2:0] w_hi0;
    logic [2:0] w_hi1;

    assign w_lo  = 3'({1'b0, x[1:0]}) + 3'({1'b0, y[1:0]}) + 3'({2'b00, carry});
    assign w_hi0 = 3'({1'b0, x[3:2]}) + 3'({1'b0, y[3:2]});
    assign w_hi1 = 3'({1'b0, x[3:2]}) + 3'({1'b0, y[3:2]}) + 3'd1;

    assign s    = w_lo[2] ? {w_hi1[1:0], w_lo[1:0]} : {w_hi0[1:0], w_lo[1:0]};
    assign cout = w_lo[2] ? w_hi1[2] : w_hi0[2];
endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
    logic [KW-1:0]    r_k;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [3:0]       w_s;
    logic             w_cout;

    carry_select u_cs (
        .x     (r_a[3:0]),
        .y     (r_b[3:0]),
        .carry (r_carry),
        .s     (w_s),
        .cout  (w_cout)
    );

    assign w_last = (r_k == KW'(NIB - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    // Operand capture, nibble shifting and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_ovf   <= 1'b0;
            r_k     <= '0;
        end else if (r_state == RUN) begin
            r_a     <= {4'b0000, r_a[WIDTH-1:4]};
            r_b     <= {4'b0000, r_b[WIDTH-1:4]};
            r_sum   <= {w_s, r_sum[WIDTH-1:4]};
            r_carry <= w_cout;
            r_k     <= w_last ? '0 : r_k + KW'(1);
            // Top nibble's MSB is the final sum sign; cin is not part of the comparison
            if (w_last) begin
                r_ovf <= (r_a_msb == r_b_msb) & (w_s[3] != r_a_msb);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
    assign bus.ovf       = r_ovf;
endmodule
